// File: rtl/music_pkg.sv
// Shared definitions for the song reader: reader FSM state encoding and
// field widths of the song ROM word {note, duration}.
package music_pkg;

  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int ROM_ADDR_W = 7;
  localparam int SONG_LEN   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    NOTIFY  = 3'd3,
    WAIT    = 3'd4,
    ADVANCE = 3'd5
  } state_t;

  // A zero duration marks the end of a song in the ROM.
  function automatic logic is_end_marker(input logic [DUR_W-1:0] dur);
    return dur == '0;
  endfunction

endpackage

// File: rtl/song_reader.sv
// Song reader: walks the song ROM one note at a time, hands each note and
// duration to the note player with a new_note pulse, and waits for the
// player's note_done before moving to the next entry.
// Optional feature: define SONG_LOOP_EN to restart the song from index 0
// at end-of-song instead of returning to IDLE.
module song_reader
  import music_pkg::*;
#(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song,
  input  logic                     note_done,
  output logic [SONG_W+IDX_W-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_dout,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     new_note,
  output logic                     song_done
);

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [SONG_W-1:0]   song_q, song_q_nxt;
  logic                song_chg;
  logic                latch_en;
  logic                end_song;
  state_t              end_state;

  // A different song select aborts whatever is in progress (IDLE just
  // captures the select when play starts).
  assign song_chg = (state != IDLE) && (song != song_q);

`ifdef SONG_LOOP_EN
  assign end_state = play ? FETCH : IDLE;
`else
  assign end_state = IDLE;
`endif

  // State, index and song-select registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      song_q <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      song_q <= song_q_nxt;
    end
  end

  // Note/duration capture; ROM data for {song_q, idx} is present in LATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      note     <= '0;
      duration <= '0;
    end else if (latch_en) begin
      note     <= rom_dout[NOTE_W+DUR_W-1:DUR_W];
      duration <= rom_dout[DUR_W-1:0];
    end
  end

  // Next-state and register-update decisions; song change wins over all.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    song_q_nxt = song_q;
    latch_en   = 1'b0;
    end_song   = 1'b0;
    if (song_chg) begin
      song_q_nxt = song;
      idx_nxt    = '0;
      state_nxt  = play ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (play) begin
            song_q_nxt = song;
            idx_nxt    = '0;
            state_nxt  = FETCH;
          end
        end
        FETCH: begin
          if (play) state_nxt = LATCH;
        end
        LATCH: begin
          latch_en = 1'b1;
          if (is_end_marker(rom_dout[DUR_W-1:0])) begin
            end_song  = 1'b1;
            idx_nxt   = '0;
            state_nxt = end_state;
          end else begin
            state_nxt = NOTIFY;
          end
        end
        NOTIFY: state_nxt = WAIT;
        WAIT: begin
          if (note_done) state_nxt = ADVANCE;
        end
        ADVANCE: begin
          // Index moves exactly once, when the reader leaves ADVANCE;
          // pausing here holds the finished note's index.
          if (&idx) begin
            end_song  = 1'b1;
            idx_nxt   = '0;
            state_nxt = end_state;
          end else if (play) begin
            idx_nxt   = idx + IDX_ONE;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: a note aborted by a song change never gets its pulse.
  always_comb begin
    rom_addr  = {song_q, idx};
    new_note  = (state == NOTIFY) && !song_chg;
    song_done = end_song;
  end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 SHALL have parameter SONG_W, default 2, song-select width (4 songs).
REQ-002 SHALL have parameter IDX_W, default 5, note-index width (32 notes per song); ROM address width is SONG_W+IDX_W = 7.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port play  in  1  level; 1 = run, 0 = pause.
REQ-006 SHALL have port song  in  SONG_W  song select.
REQ-007 SHALL have port note_done  in  1  one-cycle pulse from note player: current note finished.
REQ-008 SHALL have port rom_addr  out  7  {song_q, idx} to song ROM.
REQ-009 SHALL have port rom_dout  in  12  ROM data {note[11:6], duration[5:0]}, valid one cycle after rom_addr.
REQ-010 SHALL have port note  out  6  registered note code of current note.
REQ-011 SHALL have port duration  out  6  registered duration of current note.
REQ-012 SHALL have port new_note  out  1  one-cycle pulse: note/duration valid, start playing.
REQ-013 SHALL have port song_done  out  1  one-cycle pulse: song finished.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, LATCH, NOTIFY, WAIT, ADVANCE.
REQ-015 IDLE: play=1 -> FETCH, song_q<=song, idx<=0; else stay.
REQ-016 FETCH: rom_addr holds {song_q, idx}; play=1 -> LATCH, else hold FETCH.
REQ-017 LATCH: note<=rom_dout[11:6], duration<=rom_dout[5:0]; rom_dout[5:0]==0 -> end-of-song (REQ-022); else -> NOTIFY.
REQ-018 NOTIFY: new_note=1 for exactly this cycle; -> WAIT unconditionally.
REQ-019 WAIT: note_done=1 -> ADVANCE regardless of play; else stay; note_done outside WAIT ignored.
REQ-020 ADVANCE: idx==2^IDX_W-1 -> end-of-song; else idx<=idx+1 and, if play=1, -> FETCH, else hold ADVANCE.
REQ-021 Latency: play sampled high in IDLE -> new_note high in 4th cycle (IDLE, FETCH, LATCH, NOTIFY); note_done in WAIT -> next new_note 4 cycles later (ADVANCE, FETCH, LATCH, NOTIFY).
REQ-022 End-of-song: song_done=1 for one cycle (the ending LATCH/ADVANCE cycle), idx<=0, -> IDLE; no new_note for a zero-duration entry.
REQ-023 Song change: song != song_q in any state except IDLE -> song_q<=song, idx<=0, -> FETCH next cycle (if play=1, else IDLE); no new_note or song_done for the aborted note; takes priority over all other transitions.
REQ-024 new_note and song_done SHALL never be high in the same cycle.
REQ-025 note and duration SHALL change only in LATCH and hold otherwise.
REQ-026 idx arithmetic SHALL be unsigned IDX_W bits, no wrap beyond REQ-020/022.

Reset
REQ-027 reset=1 at a rising edge: state<=IDLE, idx<=0, song_q<=0, note<=0, duration<=0; new_note=0, song_done=0; rom_addr=0.
REQ-028 reset SHALL override every transition, including mid-note and in the same cycle as note_done or a song change.

Configuration
REQ-029 Macro SONG_LOOP_EN: defined -> end-of-song pulses song_done, idx<=0, and goes to FETCH (play=1) instead of IDLE, looping indefinitely; undefined -> REQ-022 behaviour exactly.

Structure
REQ-030 Shared package music_pkg SHALL hold state encoding, NOTE_W=6, DUR_W=6, ROM_ADDR_W=7, SONG_LEN=32.
REQ-031 No sub-module; single FSM plus index/song registers.

Verification
REQ-032 Reset, play=1, song=1, ROM addr32={35,36} -> rom_addr=32, new_note in 4th cycle, note=35, duration=36.
REQ-033 note_done in WAIT -> rom_addr=33 (ROM {42,36}), new_note 4 cycles later, note=42.
REQ-034 Song 0 run with note_done every WAIT -> after idx 31 done, song_done one pulse, IDLE, rom_addr returns to 0; with SONG_LOOP_EN, new_note at idx 0 follows.
REQ-035 ROM entry duration=0 at song 3 idx 19 (addr 115) -> song_done pulse in LATCH, no new_note.
REQ-036 song changed 1->2 during WAIT -> rom_addr=64 next cycle, no song_done, new_note 3 cycles later with ROM{43,6}.
REQ-037 play=0 in FETCH for 5 cycles, then 1 -> no new_note while paused, new_note 2 cycles after release; reset asserted in WAIT -> all outputs 0 next cycle.
